acc_seq: RTL
============

Name: acc_seq

Overview:
- Accumulator stage directly upstream and downstream of the SAP-2 ALU.
- Holds register A, which drives the ALU `a` input. Captures the ALU result back into A and maintains the Z/S status flags.
- Adds a repeat sequencer: one ALU op is re-applied N times without controller involvement, e.g. multi-bit rotates or repeated add.
- The controller sees a start/busy/done handshake.

Parameters:
- WIDTH, 8, data width of A and of the ALU result.
- BUS_W, 16, system bus width; A is loaded from bus[WIDTH-1:0].
- CNT_W, 4, repeat counter width; max repeat = 2**CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bus  input  BUS_W  system bus.
- acc_load  input  1  load A from bus[WIDTH-1:0].
- acc_wr  input  1  single-shot capture of alu_res into A.
- alu_res  input  WIDTH  ALU result (ALU `out`).
- rep_start  input  1  start repeat sequence (1-cycle pulse).
- rep_cnt  input  CNT_W  repeat count, sampled on rep_start.
- a  output  WIDTH  register A, to ALU `a` input.
- acc_bus  output  BUS_W  {zeros, A} for the bus mux.
- flag_z  output  1  A == 0 after the last write.
- flag_s  output  1  A[WIDTH-1] after the last write.
- busy  output  1  repeat sequence in progress.
- done  output  1  1-cycle pulse, sequence finished.

Behaviour:
- Reset (async, any state, including mid-sequence):
  - A=0, flag_z=1, flag_s=0, busy=0, done=0, counter=0, FSM=IDLE.
  - An in-flight repeat is abandoned with no done pulse.
- All register writes occur on the rising clk edge. A is visible on `a` the cycle after a write. The ALU is combinational, so alu_res reflects the new A in that same cycle.
- Flags are registered and update on every A write (load, wr, or repeat step), computed from the value written. They hold when A is not written.
- FSM states IDLE, RUN, DONE:
  - IDLE:
    - acc_load=1: A <= bus[WIDTH-1:0]. acc_load has priority over acc_wr and rep_start.
    - else acc_wr=1: A <= alu_res.
    - else rep_start=1 and rep_cnt!=0: cnt <= rep_cnt, go to RUN.
    - else rep_start=1 and rep_cnt==0: go to DONE; A unchanged.
  - RUN:
    - busy=1. Each cycle: A <= alu_res, cnt <= cnt-1.
    - When cnt==1 at the edge, go to DONE. Exactly rep_cnt writes occur, on consecutive cycles.
    - acc_load, acc_wr and rep_start are ignored; no queuing.
  - DONE: done=1, busy=0 for one cycle. Inputs are ignored in this cycle. Next state IDLE.
- Latency:
  - rep_start with N>0: done asserts N+1 cycles after the rep_start edge; busy is high for N cycles.
  - rep_start with N=0: done asserts the next cycle.
- The op and tmp values feeding the ALU are owned by the controller and must stay stable while busy. The block does not check this.
- Width: A wraps modulo 2**WIDTH; no overflow detection.
- acc_bus upper BUS_W-WIDTH bits are always 0.

Optional Feature:
- Macro ACC_PARITY_FLAG_EN.
- When defined: adds output port flag_p (1 bit), which is 1 when A holds an even number of ones (x86 convention). It is registered and updated on A writes like Z/S. Reset value 1.
- When undefined: no port, no logic.

Decomposition:
- Shared package sap2_pkg holds:
  - FSM state encodings ST_IDLE/ST_RUN/ST_DONE.
  - ALU op codes OP_ADD..OP_RAR (3-bit), shared with the ALU and the controller.
  - Default WIDTH/BUS_W constants.
- One natural sub-module: acc_flag_gen, combinational Z/S/(P) from a WIDTH-bit value. It is instantiated on the A next-value path.

Test Plan:
- Reset mid-RUN: assert rst during a rep_cnt=5 run -> A=0x00, z=1, s=0, busy=0, no done pulse.
- Load then capture: bus=0x1280 with acc_load -> A=0x80, s=1, z=0. Next, ALU ADD with tmp=0x80, acc_wr -> A=0x00, z=1.
- Repeat rotate: A=0x81, op=RAL, rep_start with rep_cnt=3 -> busy for 3 cycles, A sequence 0x03, 0x06, 0x0C, done on the 4th cycle.
- Zero count: rep_start with rep_cnt=0 -> done the next cycle, busy never high, A unchanged.
- Priority and ignore:
  - acc_load and acc_wr together in IDLE -> bus value wins.
  - acc_load=1, bus=0x55 while busy -> ignored, A follows the ALU only.
- Parity (ACC_PARITY_FLAG_EN): load 0x03 -> p=1; load 0x07 -> p=0; compile without the macro -> port absent.

Source files
------------

// File: rtl/sap2_pkg.sv
// Shared SAP-2 definitions: accumulator sequencer states, ALU op codes, default widths.
package sap2_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int BUS_W_DEF = 16;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } acc_state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_CMA = 3'd5,
        OP_RAL = 3'd6,
        OP_RAR = 3'd7
    } alu_op_t;

endpackage

// File: rtl/acc_seq_if.sv
// Controller <-> accumulator stage signal bundle. flag_p exists only with ACC_PARITY_FLAG_EN.
interface acc_seq_if #(
    parameter int WIDTH = 8,
    parameter int BUS_W = 16,
    parameter int CNT_W = 4
);
    logic [BUS_W-1:0] bus;
    logic             acc_load;
    logic             acc_wr;
    logic [WIDTH-1:0] alu_res;
    logic             rep_start;
    logic [CNT_W-1:0] rep_cnt;
    logic [WIDTH-1:0] a;
    logic [BUS_W-1:0] acc_bus;
    logic             flag_z;
    logic             flag_s;
    logic             busy;
    logic             done;
`ifdef ACC_PARITY_FLAG_EN
    logic             flag_p;

    modport master (
        output bus, acc_load, acc_wr, alu_res, rep_start, rep_cnt,
        input  a, acc_bus, flag_z, flag_s, flag_p, busy, done
    );
    modport slave (
        input  bus, acc_load, acc_wr, alu_res, rep_start, rep_cnt,
        output a, acc_bus, flag_z, flag_s, flag_p, busy, done
    );
`else
    modport master (
        output bus, acc_load, acc_wr, alu_res, rep_start, rep_cnt,
        input  a, acc_bus, flag_z, flag_s, busy, done
    );
    modport slave (
        input  bus, acc_load, acc_wr, alu_res, rep_start, rep_cnt,
        output a, acc_bus, flag_z, flag_s, busy, done
    );
`endif
endinterface

// File: rtl/acc_flag_gen.sv
// Combinational Z/S (and P with ACC_PARITY_FLAG_EN) status from a WIDTH-bit value.
module acc_flag_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
`ifdef ACC_PARITY_FLAG_EN
    output logic             p,
`endif
    output logic             z,
    output logic             s
);
    assign z = (value == '0);
    assign s = value[WIDTH-1];
`ifdef ACC_PARITY_FLAG_EN
    // Even number of ones -> 1.
    assign p = ~^value;
`endif
endmodule

// File: rtl/acc_seq.sv
// Accumulator A with Z/S flags and an N-times repeat sequencer around the SAP-2 ALU.
// Optional parity flag output enabled by ACC_PARITY_FLAG_EN.
module acc_seq
    import sap2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BUS_W = BUS_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic      clk,
    input logic      rst,
    acc_seq_if.slave io
);
    acc_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_next;
    logic             a_we;
    logic             z_q, s_q, z_n, s_n;
    logic             busy_q, done_q;

    // Only IDLE and RUN may write A; DONE ignores every input.
    always_comb begin
        a_we   = 1'b0;
        a_next = a_q;
        if (state == ST_IDLE) begin
            if (io.acc_load) begin
                a_we   = 1'b1;
                a_next = io.bus[WIDTH-1:0];
            end else if (io.acc_wr) begin
                a_we   = 1'b1;
                a_next = io.alu_res;
            end
        end else if (state == ST_RUN) begin
            a_we   = 1'b1;
            a_next = io.alu_res;
        end
    end

`ifdef ACC_PARITY_FLAG_EN
    logic p_q, p_n;
    acc_flag_gen #(.WIDTH(WIDTH)) u_flags (.value(a_next), .p(p_n), .z(z_n), .s(s_n));
`else
    acc_flag_gen #(.WIDTH(WIDTH)) u_flags (.value(a_next), .z(z_n), .s(s_n));
`endif

    // NOTE: all state below uses <= so every register samples pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_q    <= '0;
            z_q    <= 1'b1;
            s_q    <= 1'b0;
`ifdef ACC_PARITY_FLAG_EN
            p_q    <= 1'b1;
`endif
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (a_we) begin
                a_q <= a_next;
                z_q <= z_n;
                s_q <= s_n;
`ifdef ACC_PARITY_FLAG_EN
                p_q <= p_n;
`endif
            end
            case (state)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (!io.acc_load && !io.acc_wr && io.rep_start) begin
                        if (io.rep_cnt != '0) begin
                            cnt    <= io.rep_cnt;
                            busy_q <= 1'b1;
                            state  <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign io.a       = a_q;
    assign io.acc_bus = {{(BUS_W-WIDTH){1'b0}}, a_q};
    assign io.flag_z  = z_q;
    assign io.flag_s  = s_q;
`ifdef ACC_PARITY_FLAG_EN
    assign io.flag_p  = p_q;
`endif
    assign io.busy    = busy_q;
    assign io.done    = done_q;
endmodule
